demux_buf: RTL

//  Registered 1-to-4 demultiplexer with per-channel buffering; complement of the 4:1 data mux.

---
 rtl/demux_buf.sv | 111 +++++++++++
 1 files changed

// File: rtl/demux_buf.sv
// Registered 1-to-4 demultiplexer: one valid/ready input stream steered by sel into four FIFOs.
// Optional macro DEMUX_STATS_EN adds the acc_cnt port with per-channel saturating accept counters.
module demux_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [31:0]      acc_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [AW-1:0]    wr_ptr [4];
    logic [AW-1:0]    rd_ptr [4];
    logic [CW-1:0]    count  [4];
    logic [WIDTH-1:0] head   [4];
    logic [3:0]       full;
    logic [3:0]       empty;
    logic [3:0]       push;
    logic [3:0]       pop;

    // Ready depends only on the addressed channel, so a full channel never blocks the others.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            full[k]  = (count[k] == CW'(DEPTH));
            empty[k] = (count[k] == '0);
        end
        din_ready = ~full[sel];
        for (int k = 0; k < 4; k++) begin
            push[k] = din_valid & din_ready & (sel == 2'(k));
            pop[k]  = ~empty[k] & y_ready[k];
            head[k] = empty[k] ? '0 : mem[k][rd_ptr[k]];
        end
    end

    assign y_valid = ~empty;
    assign a       = head[0];
    assign b       = head[1];
    assign c       = head[2];
    assign d       = head[3];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + AW'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + AW'(1);
                end
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + CW'(1);
                end else if (!push[k] && pop[k]) begin
                    count[k] <= count[k] - CW'(1);
                end
            end
        end
    end

    // Storage is not reset; stale entries are masked because head is zero while empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rstn && push[k]) begin
                mem[k][wr_ptr[k]] <= din;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [7:0] stat_cnt [4];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 4; k++) begin
                stat_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k] && stat_cnt[k] != 8'hFF) begin
                    stat_cnt[k] <= stat_cnt[k] + 8'd1;
                end
            end
        end
    end

    assign acc_cnt = {stat_cnt[3], stat_cnt[2], stat_cnt[1], stat_cnt[0]};
`endif

endmodule
